// File: rtl/mdu_share_arbiter_if.sv
// Request/response and MDU handshake bundle between the requesters, the arbiter and mdu_macro.
interface mdu_share_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_funct3;
  logic [63:0] req_op_a;
  logic [63:0] req_op_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        mdu_start;
  logic        mdu_ack;
  logic [2:0]  mdu_funct3;
  logic [31:0] mdu_operand_a;
  logic [31:0] mdu_operand_b;
  logic        mdu_busy;
  logic        mdu_done;
  logic [63:0] mdu_product;
  logic [31:0] mdu_quotient;
  logic [31:0] mdu_remainder;

  modport slave (
    input  req_valid, req_funct3, req_op_a, req_op_b, rsp_ready,
           mdu_busy, mdu_done, mdu_product, mdu_quotient, mdu_remainder,
    output req_ready, rsp_valid, rsp_result, rsp_err,
           mdu_start, mdu_ack, mdu_funct3, mdu_operand_a, mdu_operand_b
  );

  modport master (
    output req_valid, req_funct3, req_op_a, req_op_b, rsp_ready,
           mdu_busy, mdu_done, mdu_product, mdu_quotient, mdu_remainder,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
           mdu_start, mdu_ack, mdu_funct3, mdu_operand_a, mdu_operand_b
  );
endinterface

// File: rtl/mdu_share_arbiter.sv
// Round-robin share of one MDU between the core pipeline (port 0) and a spare/debug requester (port 1),
// with start/done/ack sequencing, RV32M result selection, a WAIT watchdog and stale-done draining.
module mdu_share_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input logic                clk,
  input logic                rst,
  mdu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [31:0]       result_q, result_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant_sel;
  logic [31:0]       sel_result;
  logic [1:0]        req_ready_c;
  logic [1:0]        rsp_valid_c;
  logic              start_c;
  logic              ack_c;

  // Contention goes to whoever did not win last; otherwise the lone valid requester.
  assign grant_sel = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];

  // Architectural result by RV32M funct3.
  always_comb begin
    sel_result = bus.mdu_remainder;
    case (funct3_q)
      3'b000:                 sel_result = bus.mdu_product[31:0];
      3'b001, 3'b010, 3'b011: sel_result = bus.mdu_product[63:32];
      3'b100, 3'b101:         sel_result = bus.mdu_quotient;
      default:                sel_result = bus.mdu_remainder;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    funct3_d     = funct3_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    req_ready_c  = 2'b00;
    rsp_valid_c  = 2'b00;
    start_c      = 1'b0;
    ack_c        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mdu_done) begin
          // Retire a leftover done from an aborted op; nobody is accepted meanwhile.
          ack_c = 1'b1;
        end else if (bus.req_valid != 2'b00) begin
          req_ready_c[grant_sel] = 1'b1;
          grant_d  = grant_sel;
          funct3_d = grant_sel ? bus.req_funct3[5:3] : bus.req_funct3[2:0];
          op_a_d   = grant_sel ? bus.req_op_a[63:32] : bus.req_op_a[31:0];
          op_b_d   = grant_sel ? bus.req_op_b[63:32] : bus.req_op_b[31:0];
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        start_c = ~bus.mdu_busy;
        if (!bus.mdu_busy) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mdu_done) begin
          ack_c    = 1'b1;
          result_d = sel_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
          result_d = 32'hFFFF_FFFF;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid_c[grant_q] = 1'b1;
        if (bus.rsp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      funct3_q     <= 3'b000;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      result_q     <= 32'd0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      funct3_q     <= funct3_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Handshake strobes are held low while reset is applied.
  assign bus.req_ready     = rst ? 2'b00 : req_ready_c;
  assign bus.rsp_valid     = rst ? 2'b00 : rsp_valid_c;
  assign bus.mdu_start     = ~rst & start_c;
  assign bus.mdu_ack       = ~rst & ack_c;
  assign bus.rsp_result    = result_q;
  assign bus.rsp_err       = err_q;
  assign bus.mdu_funct3    = funct3_q;
  assign bus.mdu_operand_a = op_a_q;
  assign bus.mdu_operand_b = op_b_q;

endmodule

// File: tb/tb_mdu_share_arbiter.sv
// Directed bench for mdu_share_arbiter: drives both requesters and plays the MDU side.
module tb_mdu_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_share_arbiter_if bus();
  mdu_share_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  bit          use_fixed = 1'b0;
  logic [63:0] fx_prod;
  logic [31:0] fx_quo;
  logic [31:0] fx_rem;

  // MDU model: unsigned arithmetic on the latched operands, or fixed values for the select sweep.
  task automatic load_mdu();
    if (use_fixed) begin
      bus.mdu_product   = fx_prod;
      bus.mdu_quotient  = fx_quo;
      bus.mdu_remainder = fx_rem;
    end else begin
      bus.mdu_product   = {32'd0, bus.mdu_operand_a} * {32'd0, bus.mdu_operand_b};
      bus.mdu_quotient  = (bus.mdu_operand_b == 32'd0) ? 32'hFFFF_FFFF : bus.mdu_operand_a / bus.mdu_operand_b;
      bus.mdu_remainder = (bus.mdu_operand_b == 32'd0) ? bus.mdu_operand_a : bus.mdu_operand_a % bus.mdu_operand_b;
    end
  endtask

  // Runs one request from a negedge: raise vmask, wait for grant, play MDU, then complete the response.
  // hold = RESP cycles with only the wrong rsp_ready bit high before the real handshake.
  task automatic do_op(input logic [1:0] vmask, input int busy_cyc, input int done_dly, input int hold,
                       output logic gnt, output int starts, output int acks, output int start_at,
                       output int lat, output logic [1:0] vld, output logic [31:0] res,
                       output logic err, output bit held_ok);
    bit accepted, started, acked, got;
    int since;
    gnt = 1'b0; starts = 0; acks = 0; start_at = -1; lat = -1; vld = 2'b00; res = 32'd0; err = 1'b0;
    held_ok = 1'b1; accepted = 1'b0; started = 1'b0; acked = 1'b0; got = 1'b0; since = 0;
    bus.req_valid = bus.req_valid | vmask;
    for (int c = 0; c < 20 && !accepted; c++) begin
      #1;
      if (bus.req_ready != 2'b00) begin accepted = 1'b1; gnt = bus.req_ready[1]; end
      @(negedge clk);
    end
    if (!accepted) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_wait: req_ready stayed %b, required a grant", bus.req_ready);
      bus.req_valid = 2'b00;
      return;
    end
    bus.req_valid[gnt] = 1'b0;
    for (int c = 1; c < 100 && !got; c++) begin
      bus.mdu_busy = (c <= busy_cyc);
      bus.mdu_done = started && !acked && (done_dly >= 0) && (since >= done_dly);
      #1;
      if (bus.mdu_start) begin starts++; if (!started) begin start_at = c; load_mdu(); end started = 1'b1; end
      if (bus.mdu_ack) begin acks++; acked = 1'b1; end
      if (bus.rsp_valid != 2'b00) begin got = 1'b1; lat = c; vld = bus.rsp_valid; res = bus.rsp_result; err = bus.rsp_err; end
      if (started) since++;
      @(negedge clk);
    end
    bus.mdu_busy = 1'b0;
    bus.mdu_done = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_wait: rsp_valid stayed 00, required a response");
      return;
    end
    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = ~vld;
      #1;
      if (bus.rsp_valid !== vld || bus.rsp_result !== res || bus.rsp_err !== err) held_ok = 1'b0;
      if (bus.mdu_ack) acks++;
      if (bus.mdu_start) starts++;
      @(negedge clk);
    end
    bus.rsp_ready = vld;
    #1;
    if (bus.rsp_valid !== vld) held_ok = 1'b0;
    if (bus.mdu_ack) acks++;
    if (bus.mdu_start) starts++;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b01;
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_ready_gated: got %b want 00", bus.req_ready); end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL rst_req_ready: got %b want 00", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 00", bus.rsp_valid); end
    n_cmp++; if ({bus.mdu_start, bus.mdu_ack, bus.rsp_err} !== 3'b000) begin n_bad++; $display("FAIL rst_strobes: got %b want 000", {bus.mdu_start, bus.mdu_ack, bus.rsp_err}); end
    n_cmp++; if (bus.rsp_result !== 32'd0) begin n_bad++; $display("FAIL rst_result: got %h want 0", bus.rsp_result); end
    n_cmp++; if ({bus.mdu_funct3, bus.mdu_operand_a, bus.mdu_operand_b} !== 67'd0) begin n_bad++; $display("FAIL rst_latched: got %h want 0", {bus.mdu_funct3, bus.mdu_operand_a, bus.mdu_operand_b}); end
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic g; int st, ak, sa, lt; logic [1:0] v; logic [31:0] r; logic e; bit ho;
    bus.req_funct3 = {3'b000, 3'b000};
    bus.req_op_a = {32'd0, 32'd7};
    bus.req_op_b = {32'd0, 32'd6};
    do_op(2'b01, 0, 4, 2, g, st, ak, sa, lt, v, r, e, ho);
    n_cmp++; if (g !== 1'b0) begin n_bad++; $display("FAIL mul_grant: got %b want 0", g); end
    n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL mul_start_pulses: got %0d want 1", st); end
    n_cmp++; if (ak !== 1) begin n_bad++; $display("FAIL mul_ack_pulses: got %0d want 1", ak); end
    n_cmp++; if (lt !== 6) begin n_bad++; $display("FAIL mul_latency: got %0d want 6", lt); end
    n_cmp++; if (v !== 2'b01) begin n_bad++; $display("FAIL mul_rsp_valid: got %b want 01", v); end
    n_cmp++; if (r !== 32'd42) begin n_bad++; $display("FAIL mul_result: got %h want %h", r, 32'd42); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL mul_err: got %b want 0", e); end
    n_cmp++; if (ho !== 1'b1) begin n_bad++; $display("FAIL mul_rsp_hold: got %b want 1", ho); end
    bus.req_op_a = {32'd0, 32'd99};
    #1;
    n_cmp++; if (bus.mdu_operand_a !== 32'd7) begin n_bad++; $display("FAIL mul_operand_hold: got %h want 7", bus.mdu_operand_a); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic g; int st, ak, sa, lt; logic [1:0] v; logic [31:0] r; logic e; bit ho;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_funct3 = {3'b110, 3'b011};
    bus.req_op_a = {32'd17, 32'hFFFF_FFFF};
    bus.req_op_b = {32'd5, 32'hFFFF_FFFF};
    do_op(2'b11, 0, 2, 0, g, st, ak, sa, lt, v, r, e, ho);
    n_cmp++; if (g !== 1'b0) begin n_bad++; $display("FAIL cont1_grant: got %b want 0", g); end
    n_cmp++; if (r !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL cont1_mulhu: got %h want fffffffe", r); end
    n_cmp++; if (v !== 2'b01) begin n_bad++; $display("FAIL cont1_rsp_valid: got %b want 01", v); end
    do_op(2'b10, 0, 1, 0, g, st, ak, sa, lt, v, r, e, ho);
    n_cmp++; if (g !== 1'b1) begin n_bad++; $display("FAIL cont2_grant: got %b want 1", g); end
    n_cmp++; if (r !== 32'd2) begin n_bad++; $display("FAIL cont2_rem: got %h want 2", r); end
    n_cmp++; if (v !== 2'b10) begin n_bad++; $display("FAIL cont2_rsp_valid: got %b want 10", v); end
    do_op(2'b11, 0, 1, 0, g, st, ak, sa, lt, v, r, e, ho);
    bus.req_valid = 2'b00;
    n_cmp++; if (g !== 1'b0) begin n_bad++; $display("FAIL cont3_grant: got %b want 0", g); end
    n_cmp++; if (r !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL cont3_mulhu: got %h want fffffffe", r); end
    @(negedge clk);
  endtask

  task automatic test_funct3_sweep();
    logic g; int st, ak, sa, lt; logic [1:0] v; logic [31:0] r; logic e; bit ho;
    logic [31:0] exp_tab [8];
    exp_tab = '{32'h3333_4444, 32'h1111_2222, 32'h1111_2222, 32'h1111_2222, 32'd5, 32'd5, 32'd9, 32'd9};
    use_fixed = 1'b1;
    fx_prod = 64'h1111_2222_3333_4444;
    fx_quo  = 32'd5;
    fx_rem  = 32'd9;
    bus.req_op_a = 64'd1;
    bus.req_op_b = 64'd1;
    for (int f = 0; f < 8; f++) begin
      bus.req_funct3 = {3'b000, 3'(f)};
      do_op(2'b01, 0, 1, 0, g, st, ak, sa, lt, v, r, e, ho);
      n_cmp++; if (r !== exp_tab[f]) begin n_bad++; $display("FAIL sweep_f%0d: got %h want %h", f, r, exp_tab[f]); end
      n_cmp++; if (lt !== 3) begin n_bad++; $display("FAIL sweep_lat_f%0d: got %0d want 3", f, lt); end
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_busy_stall();
    logic g; int st, ak, sa, lt; logic [1:0] v; logic [31:0] r; logic e; bit ho;
    bus.req_funct3 = {3'b000, 3'b000};
    bus.req_op_a = {32'd0, 32'd3};
    bus.req_op_b = {32'd0, 32'd5};
    do_op(2'b01, 10, 1, 0, g, st, ak, sa, lt, v, r, e, ho);
    n_cmp++; if (sa !== 11) begin n_bad++; $display("FAIL busy_start_cycle: got %0d want 11", sa); end
    n_cmp++; if (st !== 1) begin n_bad++; $display("FAIL busy_start_pulses: got %0d want 1", st); end
    n_cmp++; if (lt !== 13) begin n_bad++; $display("FAIL busy_latency: got %0d want 13", lt); end
    n_cmp++; if ({e, r} !== {1'b0, 32'd15}) begin n_bad++; $display("FAIL busy_result: got %b/%h want 0/f", e, r); end
  endtask

  task automatic test_timeout_drain();
    logic g; int st, ak, sa, lt; logic [1:0] v; logic [31:0] r; logic e; bit ho;
    bus.req_funct3 = {3'b000, 3'b101};
    bus.req_op_a = {32'd0, 32'd100};
    bus.req_op_b = {32'd0, 32'd7};
    do_op(2'b01, 0, -1, 0, g, st, ak, sa, lt, v, r, e, ho);
    n_cmp++; if (lt !== 10) begin n_bad++; $display("FAIL to_latency: got %0d want 10", lt); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", e); end
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL to_result: got %h want ffffffff", r); end
    n_cmp++; if (ak !== 0) begin n_bad++; $display("FAIL to_no_ack: got %0d want 0", ak); end
    bus.mdu_done = 1'b1;
    bus.req_valid = 2'b01;
    #1;
    n_cmp++; if (bus.mdu_ack !== 1'b1) begin n_bad++; $display("FAIL drain_ack: got %b want 1", bus.mdu_ack); end
    n_cmp++; if (bus.req_ready !== 2'b00) begin n_bad++; $display("FAIL drain_ready: got %b want 00", bus.req_ready); end
    @(negedge clk);
    bus.mdu_done = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL drain_no_accept: got %b want 01", bus.req_ready); end
    n_cmp++; if (bus.mdu_ack !== 1'b0) begin n_bad++; $display("FAIL drain_ack_clear: got %b want 0", bus.mdu_ack); end
    bus.req_valid = 2'b00;
    @(negedge clk);
    do_op(2'b01, 0, 2, 0, g, st, ak, sa, lt, v, r, e, ho);
    n_cmp++; if ({e, r} !== {1'b0, 32'd14}) begin n_bad++; $display("FAIL after_to_divu: got %b/%h want 0/e", e, r); end
  endtask

  task automatic test_reset_abort();
    logic g; int st, ak, sa, lt; logic [1:0] v; logic [31:0] r; logic e; bit ho;
    bus.req_funct3 = {3'b000, 3'b000};
    bus.req_op_a = {32'd0, 32'd3};
    bus.req_op_b = {32'd0, 32'd4};
    bus.req_valid = 2'b01;
    #1;
    n_cmp++; if (bus.req_ready !== 2'b01) begin n_bad++; $display("FAIL abort_grant: got %b want 01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    n_cmp++; if (bus.mdu_start !== 1'b1) begin n_bad++; $display("FAIL abort_start: got %b want 1", bus.mdu_start); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.mdu_done = 1'b1;
    #1;
    n_cmp++; if (bus.mdu_ack !== 1'b1) begin n_bad++; $display("FAIL abort_drain_ack: got %b want 1", bus.mdu_ack); end
    n_cmp++; if ({bus.rsp_valid, bus.req_ready, bus.mdu_start} !== 5'b0) begin n_bad++; $display("FAIL abort_strobes: got %b want 00000", {bus.rsp_valid, bus.req_ready, bus.mdu_start}); end
    n_cmp++; if ({bus.rsp_err, bus.rsp_result, bus.mdu_funct3, bus.mdu_operand_a, bus.mdu_operand_b} !== 100'd0) begin n_bad++; $display("FAIL abort_regs_zero: got %h want 0", {bus.rsp_err, bus.rsp_result, bus.mdu_funct3, bus.mdu_operand_a, bus.mdu_operand_b}); end
    @(negedge clk);
    bus.mdu_done = 1'b0;
    #1;
    n_cmp++; if ({bus.mdu_ack, bus.rsp_valid} !== 3'b000) begin n_bad++; $display("FAIL abort_quiet: got %b want 000", {bus.mdu_ack, bus.rsp_valid}); end
    @(negedge clk);
    do_op(2'b01, 0, 1, 0, g, st, ak, sa, lt, v, r, e, ho);
    n_cmp++; if ({e, r} !== {1'b0, 32'd12}) begin n_bad++; $display("FAIL abort_next_op: got %b/%h want 0/c", e, r); end
    n_cmp++; if ({st, ak} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL abort_next_pulses: got %0d/%0d want 1/1", st, ak); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b00; bus.req_funct3 = 6'd0; bus.req_op_a = 64'd0; bus.req_op_b = 64'd0;
    bus.rsp_ready = 2'b00; bus.mdu_busy = 1'b0; bus.mdu_done = 1'b0;
    bus.mdu_product = 64'd0; bus.mdu_quotient = 32'd0; bus.mdu_remainder = 32'd0;
    fx_prod = 64'd0; fx_quo = 32'd0; fx_rem = 32'd0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_contention();
    test_funct3_sweep();
    test_busy_stall();
    test_timeout_drain();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_limit: simulation still running, required completion");
    $fatal(1);
  end
endmodule

// File: doc/mdu_share_arbiter.md
Name: mdu_share_arbiter

Overview:
Shares the single mdu_macro instance between two requesters: port 0 is the core pipeline and port 1 is the spare/debug requester. It arbitrates round-robin and sequences the MDU start/done/ack handshake. It also selects the 32-bit architectural result from product/quotient/remainder by funct3. A watchdog covers a hung MDU, and stale results left by an aborted operation are drained. The block sits between core_macro-side requesters and mdu_macro in the hierarchical top.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles in WAIT before an error response; 0 disables the watchdog.
CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  sole clock; all logic on rising edge
rst  in  1  reset; one clock, reset is synchronous and active-high
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester accept; at most one bit high
req_funct3  in  6  {funct3_1, funct3_0}, RV32M funct3
req_op_a  in  64  {a_1, a_0}
req_op_b  in  64  {b_1, b_0}
rsp_valid  out  2  result valid for requester i; at most one bit high
rsp_ready  in  2  requester i consumes result
rsp_result  out  32  selected result of the granted requester
rsp_err  out  1  qualifies rsp_valid: watchdog expired, result invalid
mdu_start  out  1  one-cycle start pulse to the MDU
mdu_ack  out  1  one-cycle retire pulse to the MDU
mdu_funct3  out  3  latched funct3
mdu_operand_a  out  32  latched operand A
mdu_operand_b  out  32  latched operand B
mdu_busy  in  1  MDU computing; start is ignored while high
mdu_done  in  1  level; held until ack
mdu_product  in  64  multiply result
mdu_quotient  in  32  divide quotient
mdu_remainder  in  32  divide remainder

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset values: state=IDLE, last_grant=1 (requester 0 wins first), all outputs 0, latched operands/funct3/result 0, counter 0.
- IDLE, grant:
  - grant = the single valid requester; if both are valid, grant = !last_grant.
  - req_ready[grant] = 1 combinationally. On the accept edge (valid&ready): latch funct3/op_a/op_b/grant, go to ISSUE.
- IDLE, stale-done drain:
  - If mdu_done=1 in IDLE, assert mdu_ack that cycle and hold req_ready=0. No accept occurs in a drain cycle.
- ISSUE: mdu_start = !mdu_busy (combinational). On the edge with start=1, go to WAIT and clear the counter. Busy stalls indefinitely; no timeout in ISSUE.
- WAIT:
  - On mdu_done=1: mdu_ack=1 the same cycle, capture the selected result, rsp_err=0, go to RESP.
  - Else the counter increments. If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without done: result=32'hFFFF_FFFF, rsp_err=1, go to RESP.
- Result select:
  - funct3 000 -> product[31:0].
  - 001/010/011 -> product[63:32].
  - 100/101 -> quotient.
  - 110/111 -> remainder.
- RESP:
  - rsp_valid[grant]=1; rsp_result/rsp_err are stable until handshake.
  - On rsp_ready[grant]: last_grant=grant, go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- mdu_funct3/operands are registered and hold their last latched values between ops.
- Minimum latency, accept to rsp_valid: 3 cycles if the MDU asserts done the cycle after start (accept -> ISSUE -> WAIT -> RESP).
- Back-to-back: a new accept is possible the cycle after the RESP handshake.
- rst mid-operation (any state): the FSM returns to IDLE with no response. A late mdu_done from the aborted op is drained by the IDLE rule. A busy MDU is tolerated by ISSUE stalling.
- Requester-side rules: req_valid must stay high until accepted; operands may change after accept; a requester may hold rsp_ready low indefinitely.

Test Plan:
- r0 MUL a=7, b=6; MDU done 4 cycles after start -> one mdu_start pulse, one mdu_ack pulse; rsp_valid=01, rsp_result=42, rsp_err=0.
- Both valid at reset: r0 MULHU a=b=32'hFFFF_FFFF, r1 REM a=17, b=5 -> r0 granted first with result 32'hFFFF_FFFE, then r1 with result 2; a further contention grants r0 again.
- funct3 sweep 000-111 with product=64'h1111_2222_3333_4444, quotient=5, remainder=9 -> results 3333_4444, 1111_2222 (x3), 5, 5, 9, 9.
- mdu_busy held for 10 cycles in ISSUE -> mdu_start is asserted only on the first cycle busy=0; no timeout occurs.
- TIMEOUT_CYCLES=8, done never arrives -> RESP after 8 WAIT cycles with rsp_err=1, rsp_result=FFFF_FFFF. A later mdu_done in IDLE gets mdu_ack, and no accept occurs that cycle.
- rst for one cycle while in WAIT, then mdu_done arrives -> all outputs return to 0, mdu_ack drains the done, no rsp_valid is asserted, and the next request completes normally.
